// File: rtl/adder_tree_rr_sched.sv
// Round-robin scheduler that shares one pipelined adder tree among REQ_N
// requesters and returns each tree sum with the tag of its requester.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_req_valid/data      per-requester operand vectors
//   o_req_ready           one-hot combinational grant
//   i_hold                suppresses new issue; in-flight work drains
//   o_tree_data/valid     registered issue to the adder tree
//   i_tree_sum            tree result, TREE_LAT cycles after issue
//   o_res_valid/id/data   tagged result strobe
//   o_busy                work issued but not yet returned
//   o_issue_cnt           wrapping count of accepted vectors
module adder_tree_rr_sched #(
    parameter int REQ_N    = 4,
    parameter int I_DATA_W = 3,
    parameter int I_DATA_N = 8,
    parameter int O_DATA_W = 7,
    parameter int TREE_LAT = 3
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [REQ_N-1:0]                              i_req_valid,
    input  logic [0:REQ_N-1][0:I_DATA_N-1][I_DATA_W-1:0]  i_req_data,
    output logic [REQ_N-1:0]                              o_req_ready,
    input  logic                                          i_hold,
    output logic [0:I_DATA_N-1][I_DATA_W-1:0]             o_tree_data,
    output logic                                          o_tree_valid,
    input  logic [O_DATA_W-1:0]                           i_tree_sum,
    output logic                                          o_res_valid,
    output logic [$clog2(REQ_N)-1:0]                      o_res_id,
    output logic [O_DATA_W-1:0]                           o_res_data,
    output logic                                          o_busy,
    output logic [15:0]                                   o_issue_cnt
);

    localparam int ID_W = $clog2(REQ_N);

    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     ptr_nxt;
    logic [ID_W-1:0]     issue_id;
    logic [ID_W-1:0]     gidx;
    logic [ID_W-1:0]     scan;
    logic                gany;
    logic [TREE_LAT-1:0] tag_v;
    logic [ID_W-1:0]     tag_id [TREE_LAT];

    // Scan upward from ptr (mod REQ_N); first valid requester wins.
    always_comb begin
        gany        = 1'b0;
        gidx        = '0;
        scan        = '0;
        o_req_ready = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (int'(ptr) + i >= REQ_N)
                scan = ID_W'(int'(ptr) + i - REQ_N);
            else
                scan = ID_W'(int'(ptr) + i);
            if (!gany && i_req_valid[scan]) begin
                gany = 1'b1;
                gidx = scan;
            end
        end
        if (rst || i_hold)
            gany = 1'b0;
        if (gany)
            o_req_ready[gidx] = 1'b1;
    end

    always_comb begin
        if (int'(gidx) == REQ_N - 1)
            ptr_nxt = '0;
        else
            ptr_nxt = gidx + ID_W'(1);
    end

    assign o_busy = o_tree_valid | (|tag_v);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            issue_id     <= '0;
            o_tree_data  <= '0;
            o_tree_valid <= 1'b0;
            o_issue_cnt  <= '0;
            tag_v        <= '0;
            for (int k = 0; k < TREE_LAT; k++)
                tag_id[k] <= '0;
            o_res_valid  <= 1'b0;
            o_res_id     <= '0;
            o_res_data   <= '0;
        end else begin
            o_tree_valid <= gany;
            if (gany) begin
                ptr         <= ptr_nxt;
                issue_id    <= gidx;
                o_tree_data <= i_req_data[gidx];
                o_issue_cnt <= o_issue_cnt + 16'd1;
            end
            // Tags follow the vector through the tree, one stage per cycle.
            tag_v[0]  <= o_tree_valid;
            tag_id[0] <= issue_id;
            for (int k = 1; k < TREE_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            o_res_valid <= tag_v[TREE_LAT-1];
            if (tag_v[TREE_LAT-1]) begin
                o_res_id   <= tag_id[TREE_LAT-1];
                o_res_data <= i_tree_sum;
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_rr_sched.sv
// Bench for adder_tree_rr_sched: ideal-sum tree model plus a result
// scoreboard of expected {id, sum, accept cycle}.
module tb_adder_tree_rr_sched;

    localparam int REQ_N = 4;
    localparam int DW    = 3;
    localparam int DN    = 8;
    localparam int OW    = 7;
    localparam int LAT   = 3;

    typedef struct {
        int id;
        int sum;
        int cyc;
    } exp_t;

    logic                             clk = 1'b0;
    logic                             rst;
    logic [REQ_N-1:0]                 req_valid;
    logic [0:REQ_N-1][0:DN-1][DW-1:0] req_data;
    logic [REQ_N-1:0]                 req_ready;
    logic                             hold;
    logic [0:DN-1][DW-1:0]            tree_data;
    logic                             tree_valid;
    logic [OW-1:0]                    tree_sum;
    logic                             res_valid;
    logic [1:0]                       res_id;
    logic [OW-1:0]                    res_data;
    logic                             busy;
    logic [15:0]                      issue_cnt;

    logic [OW-1:0] pipe [LAT];
    exp_t          sb [$];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;

    adder_tree_rr_sched #(
        .REQ_N(REQ_N), .I_DATA_W(DW), .I_DATA_N(DN),
        .O_DATA_W(OW), .TREE_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .i_req_data(req_data),
        .o_req_ready(req_ready), .i_hold(hold),
        .o_tree_data(tree_data), .o_tree_valid(tree_valid),
        .i_tree_sum(tree_sum),
        .o_res_valid(res_valid), .o_res_id(res_id),
        .o_res_data(res_data), .o_busy(busy),
        .o_issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    function automatic int vsum(input logic [0:DN-1][DW-1:0] v);
        int s = 0;
        for (int i = 0; i < DN; i++)
            s += int'(v[i]);
        return s % (1 << OW);
    endfunction

    // Ideal tree: sum visible LAT cycles after o_tree_data is presented.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        pipe[0] <= OW'(vsum(tree_data));
        for (int k = 1; k < LAT; k++)
            pipe[k] <= pipe[k-1];
    end
    assign tree_sum = pipe[LAT-1];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [REQ_N-1:0] oh);
        int r = 0;
        for (int i = 0; i < REQ_N; i++)
            if (oh[i]) r = i;
        return r;
    endfunction

    // Results monitor: every strobe must match the oldest outstanding entry.
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_res", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_id", int'(res_id), e.id);
                chk("res_data", int'(res_data), e.sum);
                chk("res_lat", cyc - e.cyc, LAT + 2);
            end
        end
    end

    // One cycle: drive at negedge, check grant, then check issue next cycle.
    task automatic drive(input logic [3:0] v, input logic h,
                         input logic [3:0] er);
        int g;
        exp_t e;
        req_valid = v;
        hold      = h;
        #1;
        chk("ready", int'(req_ready), int'(er));
        g = oh_idx(er);
        if (er != 0) begin
            e.id  = g;
            e.sum = vsum(req_data[g]);
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("tree_valid", int'(tree_valid), int'(er != 0));
        if (er != 0)
            chk("tree_data", int'(tree_data), int'(req_data[g]));
    endtask

    task automatic drain();
        int n = 0;
        req_valid = '0;
        hold      = 1'b0;
        while ((busy || sb.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", int'(busy || sb.size() != 0), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '1;
        #1;
        chk("ready_in_rst", int'(req_ready), 0);
        @(negedge clk);
        @(negedge clk);
        sb.delete();
        rst = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = '0;
        for (int k = 0; k < REQ_N; k++)
            for (int i = 0; i < DN; i++)
                req_data[k][i] = DW'(k + 1);
        @(negedge clk);
        do_reset();

        chk("rst_tree_valid", int'(tree_valid), 0);
        chk("rst_tree_data", int'(tree_data), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(issue_cnt), 0);

        // Single requester 0, all operands 5 -> sum 40.
        for (int i = 0; i < DN; i++)
            req_data[0][i] = 3'd5;
        drive(4'b0001, 1'b0, 4'b0001);
        chk("busy_after_issue", int'(busy), 1);
        drain();
        chk("cnt_one", int'(issue_cnt), 1);
        for (int i = 0; i < DN; i++)
            req_data[0][i] = 3'd1;

        // All four continuously: strict rotation from 0.
        do_reset();
        for (int n = 0; n < 8; n++)
            drive(4'b1111, 1'b0, 4'(1 << (n % 4)));
        drain();
        chk("cnt_eight", int'(issue_cnt), 8);

        // ptr=2 with requesters 1,3: grant 3, then 1, then ptr back at 2.
        drive(4'b0010, 1'b0, 4'b0010);
        drive(4'b1010, 1'b0, 4'b1000);
        drive(4'b1010, 1'b0, 4'b0010);
        drive(4'b1011, 1'b0, 4'b1000);
        drain();

        // Hold for 3 cycles mid-stream; ptr frozen at 2.
        drive(4'b1111, 1'b0, 4'b0001);
        drive(4'b1111, 1'b0, 4'b0010);
        drive(4'b1111, 1'b1, 4'b0000);
        drive(4'b1111, 1'b1, 4'b0000);
        drive(4'b1111, 1'b1, 4'b0000);
        drive(4'b1111, 1'b0, 4'b0100);
        drive(4'b1111, 1'b0, 4'b1000);
        drain();

        // Reset with three vectors in flight: all dropped.
        drive(4'b1111, 1'b0, 4'b0001);
        drive(4'b1111, 1'b0, 4'b0010);
        drive(4'b1111, 1'b0, 4'b0100);
        sb.delete();
        rst = 1'b1;
        #1;
        chk("ready_mid_rst", int'(req_ready), 0);
        @(negedge clk);
        chk("busy_after_rst", int'(busy), 0);
        chk("cnt_after_rst", int'(issue_cnt), 0);
        chk("tvalid_after_rst", int'(tree_valid), 0);
        rst = 1'b0;
        drive(4'b1111, 1'b0, 4'b0001);
        drain();
        repeat (6) @(negedge clk);

        // Counter wrap over 65537 grants with varying data.
        do_reset();
        for (int n = 0; n < 65537; n++) begin
            for (int i = 0; i < DN; i++)
                req_data[0][i] = DW'($urandom_range(0, 7));
            drive(4'b0001, 1'b0, 4'b0001);
            if (n == 65534)
                chk("cnt_ffff", int'(issue_cnt), 16'hffff);
            if (n == 65535)
                chk("cnt_wrap0", int'(issue_cnt), 0);
        end
        chk("cnt_wrap1", int'(issue_cnt), 1);
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_tree_rr_sched.md
# adder_tree_rr_sched

Round-robin scheduler that shares one pipelined CSA adder tree (`I_DATA_N` operands of `I_DATA_W` bits, fixed latency `TREE_LAT`) between `REQ_N` requesters. It arbitrates one operand vector per cycle into the tree and tracks each issued vector with a requester tag. It returns each sum to the originating requester with a tag. The block sits between the requesting datapaths and the `adder_tree_csa` instance and owns all of its sequencing.

## Interface
- `REQ_N`, 4: number of requesters (2..16); `ID_W = $clog2(REQ_N)` is a localparam.
- `I_DATA_W`, 3: operand width.
- `I_DATA_N`, 8: operands per vector.
- `O_DATA_W`, 7: tree sum width (I_DATA_W + tree stages + 1).
- `TREE_LAT`, 3: tree latency in cycles, from `o_tree_data`/`o_tree_valid` register to `i_tree_sum` valid (≥1).
- `clk  in  1`: single clock; all logic on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `i_req_valid  in  REQ_N`: per-requester request.
- `i_req_data  in  [0:REQ_N-1][0:I_DATA_N-1][I_DATA_W-1:0]`: per-requester operand vectors.
- `o_req_ready  out  REQ_N`: one-hot grant (combinational); a transfer happens when valid & ready.
- `i_hold  in  1`: blocks new issue; in-flight work still drains.
- `o_tree_data  out  [0:I_DATA_N-1][I_DATA_W-1:0]`: registered operands to the tree.
- `o_tree_valid  out  1`: registered; marks a real issue.
- `i_tree_sum  in  O_DATA_W`: tree output.
- `o_res_valid  out  1`: result strobe, one cycle.
- `o_res_id  out  ID_W`: requester index of the result.
- `o_res_data  out  O_DATA_W`: registered sum.
- `o_busy  out  1`: high while any issued vector has not yet produced `o_res_valid`.
- `o_issue_cnt  out  16`: count of accepted vectors; wraps at 2^16.

## Operation
- Priority pointer `ptr` (ID_W bits). Search starts at `ptr` and scans upward modulo REQ_N. The first asserted `i_req_valid` wins, and only that bit of `o_req_ready` is set.
- After a grant to index g: `ptr <= (g+1) mod REQ_N`. With no grant, `ptr` is unchanged.
- `i_hold=1`: `o_req_ready=0`, no issue, `ptr` frozen. The tag pipeline keeps shifting.
- On a grant, the next cycle `o_tree_data <= i_req_data[g]`, `o_tree_valid <= 1`, and {valid, g} enters tag pipeline stage 0. With no grant, `o_tree_valid <= 0` and `o_tree_data` holds its last value.
- Tag pipeline: TREE_LAT stages of {valid, id}, shifting every cycle with no stalls. The tree has no backpressure, so result consumers must accept every `o_res_valid`.
- When the last tag stage is valid: `o_res_valid <= 1`, `o_res_id <= tag id`, `o_res_data <= i_tree_sum`. Otherwise `o_res_valid <= 0` and data/id hold their values.
- `o_busy` = `o_tree_valid` OR any tag stage valid.
- `o_issue_cnt` increments by 1 per grant. It goes from 0xFFFF to 0x0000 with no flag.
- Sums are the tree's job. The scheduler performs no arithmetic on data, only width-preserving transport.

## Timing
- Accept in cycle c (valid & ready high at edge c):
  - `o_tree_valid` is high in c+1.
  - `i_tree_sum` is valid in c+1+TREE_LAT.
  - `o_res_valid` is high in c+2+TREE_LAT.
  - Total latency is TREE_LAT+2 cycles.
- Throughput: one vector per cycle. Results leave in issue order, one per cycle, with no gaps beyond issue gaps.
- A single active requester is granted every cycle it holds valid.
- With all REQ_N requesters active, grants rotate strictly; each requester gets exactly 1 of every REQ_N cycles.
- `i_hold` sampled high in cycle c means no grant in c. Release gives a grant in the same cycle `i_hold` drops.
- Reset values:
  - `ptr=0`, all tag stages invalid.
  - `o_tree_valid=0`, `o_tree_data=0`.
  - `o_res_valid=0`, `o_res_id=0`, `o_res_data=0`.
  - `o_busy=0`, `o_issue_cnt=0`.
  - `o_req_ready=0` while `rst` is high.
- Reset mid-operation: all in-flight vectors are dropped, with no `o_res_valid` for them even though the tree still emits sums. Arbitration restarts from index 0 in the first cycle after `rst` falls.
- `i_req_valid` dropping without a handshake is legal and has no effect on state.

## Test plan
- Requester 0 only, data all 3'd5 (REQ_N=4, TREE_LAT=3, tree model = ideal sum) -> `o_req_ready=4'b0001`, `o_tree_valid` at c+1, `o_res_valid` at c+5 with `o_res_id=0`, `o_res_data=40`, `o_issue_cnt=1`.
- All four valid continuously for 8 cycles, requester k data all k+1 -> grants 0,1,2,3,0,1,2,3 with no gap; results ids 0,1,2,3,0,1,2,3 with sums 8,16,24,32 repeating.
- Requesters 1 and 3 valid, ptr=2 -> grant 3 then 1, ptr becomes 0 then 2.
- `i_hold` high for 3 cycles during continuous requests -> `o_req_ready=0` and 3 bubbles on `o_tree_valid`. Results already in flight still appear, and the rotation resumes from the frozen ptr.
- `rst` pulsed with 3 vectors in flight -> no `o_res_valid` for them, `o_busy=0`, `o_issue_cnt=0`, first grant after reset goes to requester 0 if valid.
- 65,537 single-requester grants -> `o_issue_cnt` wraps 0xFFFF→0x0000→0x0001, and the last result arrives with the correct id and sum.
